// File: rtl/demux_reg_rs.sv
// Registered 1-to-2 demultiplexer: one valid/ready stream steered by sel into
// two independently drained 2-entry FIFOs (ibits when sel=1, rbits when sel=0).

module demux_reg_rs_fifo #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_count;

    // Storage is cleared on reset so the head reads 0 while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= ~r_wp;
            end
            if (i_pop) begin
                r_rp <= ~r_rp;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rp];
    assign o_count = r_count;

endmodule

module demux_reg_rs #(
    parameter int N = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [N:0] in_bits,
    input  logic       sel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [N:0] ibits,
    output logic       ibits_valid,
    input  logic       ibits_ready,
    output logic [N:0] rbits,
    output logic       rbits_valid,
    input  logic       rbits_ready,
    output logic [1:0] ibits_count,
    output logic [1:0] rbits_count
);

    logic w_accept;
    logic w_push_i;
    logic w_push_r;
    logic w_pop_i;
    logic w_pop_r;

    // Registered counts only: a same-cycle pop on a full channel does not open in_ready.
    assign in_ready    = sel ? (ibits_count != 2'd2) : (rbits_count != 2'd2);
    assign w_accept    = in_valid && in_ready;
    assign w_push_i    = w_accept && sel;
    assign w_push_r    = w_accept && !sel;

    assign ibits_valid = (ibits_count != 2'd0);
    assign rbits_valid = (rbits_count != 2'd0);
    assign w_pop_i     = ibits_valid && ibits_ready;
    assign w_pop_r     = rbits_valid && rbits_ready;

    demux_reg_rs_fifo #(.W(N + 1)) u_ififo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_i),
        .i_wdata (in_bits),
        .i_pop   (w_pop_i),
        .o_head  (ibits),
        .o_count (ibits_count)
    );

    demux_reg_rs_fifo #(.W(N + 1)) u_rfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_r),
        .i_wdata (in_bits),
        .i_pop   (w_pop_r),
        .o_head  (rbits),
        .o_count (rbits_count)
    );

endmodule

// File: doc/demux_reg_rs.md
# demux_reg_rs

Registered 1-to-2 demultiplexer with per-channel buffering: the producer-side counterpart of the immediate/register 2:1 operand mux. A single valid/ready input stream of (N+1)-bit words is steered by `sel` into either the immediate channel (`ibits`) or the register channel (`rbits`). Each channel is buffered in a 2-entry FIFO with its own valid/ready handshake, so the channels drain independently. The block sits between operand decode and the consumers that later recombine the two operand paths.

## Interface
- `N`, default 2: MSB index; all data paths are N+1 bits wide.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_bits` input, N+1 bits: incoming word.
- `sel` input, 1 bit: 1 routes to the ibits channel, 0 routes to the rbits channel. Sampled with `in_bits` on accept.
- `in_valid` input, 1 bit: producer has a word.
- `in_ready` output, 1 bit: the channel selected by the current `sel` has space.
- `ibits` output, N+1 bits: head of the ibits FIFO.
- `ibits_valid` output, 1 bit; `ibits_ready` input, 1 bit.
- `rbits` output, N+1 bits: head of the rbits FIFO.
- `rbits_valid` output, 1 bit; `rbits_ready` input, 1 bit.
- `ibits_count` output, 2 bits; `rbits_count` output, 2 bits: current occupancy of each FIFO (0..2).

## Operation
- **Channels.** Each channel is a 2-entry FIFO with write pointer, read pointer and a 2-bit count. Data, pointers and count are registered.
- **Accept.** A word is accepted on a rising edge when `in_valid && in_ready`. It is written to the ibits FIFO if `sel`=1, otherwise to the rbits FIFO.
- **`in_ready`.** Combinational: `sel ? (ibits_count != 2) : (rbits_count != 2)`. It uses registered counts only, so a same-cycle pop on a full channel does NOT open `in_ready`.
- **Pop.** A channel pops on a rising edge when `X_valid && X_ready`.
- **`X_valid`.** Equals `X_count != 0`. `X` (ibits or rbits) always shows the oldest entry.
- **Count update** per channel:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, with both pointers advancing
- **Ordering.** Order is preserved within a channel. There is no ordering relation between channels.
- **Isolation.** The unselected channel is never written. A stall on one channel does not block pops from the other.
- **Holding outputs.** While `X_valid`=1 and `X_ready`=0, `X` and `X_valid` stay stable.
- **Stall.** If `in_valid`=0 or `in_ready`=0, nothing is written. `in_bits` and `sel` are don't-care when `in_valid`=0.
- **Pointer wrap.** Pointers are 1 bit and wrap from 1 to 0 naturally.
- **Illegal pop.** A pop on an empty channel is impossible, because `valid`=0 there.
- **Reset.** Asserting `rst_n`=0 at any time, including mid-transfer, immediately clears all pointers and counts and all FIFO storage to 0. Buffered words are discarded.
- **Reset values:**
  - `ibits` = `rbits` = 0
  - `ibits_valid` = `rbits_valid` = 0
  - `ibits_count` = `rbits_count` = 0
  - `in_ready` = 1, for either `sel`

## Timing
- **Latency.** Input-to-output latency is 1 cycle. A word accepted at edge k appears on `X` with `X_valid`=1 after edge k, if its channel was empty.
- **Throughput.** Sustained throughput is 1 word/cycle per channel when the consumer holds `ready`=1. The channel then stays at count ≤ 1.
- **Combinational paths.** There is no combinational path from `in_valid` or `in_bits` to any output. The only combinational input-to-output path is `sel` → `in_ready`. `X_ready` affects only state, never a same-cycle output.
- **Async reset.** Assertion is asynchronous. Deassertion is expected synchronous to `clk` (external synchronizer). The first accept can occur on the first rising edge with `rst_n`=1.

## Test plan
- **Reset.** Drive `rst_n`=0 mid-stream with both FIFOs holding 2 words.
  - Required: all valids = 0, counts = 0, data = 0 immediately, before the next edge.
  - Required: after release, `in_ready`=1.
- **Steering and ordering.** Use N=2. Push 3'h5 (`sel`=1), then 3'h2 (`sel`=0), then 3'h7 (`sel`=1), with both `ready`=0.
  - Required: `ibits_count`=2 with `ibits`=3'h5; `rbits_count`=1 with `rbits`=3'h2.
  - Then pulse `ibits_ready` for 1 cycle. Required: `ibits`=3'h7 and count=1.
- **Full channel.** Fill ibits (count=2) and hold `sel`=1 with `in_valid`=1. Required: `in_ready`=0 and no write.
  - Switch `sel`=0 the same cycle. Required: `in_ready`=1 and the word lands in rbits.
- **Pop while full.** With ibits full, assert `ibits_ready`=1 and `in_valid`=1 with `sel`=1.
  - Required: the edge pops only; count goes 2→1.
  - On the next edge push+pop happens together and the count stays 1.
- **Streaming.** Feed 8 consecutive words 0..7 alternating `sel`, with both `ready`=1.
  - Required: `ibits` delivers 1,3,5,7 and `rbits` delivers 0,2,4,6, each 1 cycle after accept.
  - Required: counts never exceed 1.
- **Independent stall.** Hold `rbits_ready`=0 while streaming to ibits only.
  - Required: ibits throughput is 1/cycle.
  - Required: `rbits_valid` and `rbits` stay stable throughout.
